// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add/subtract engine. Two WIDTH-bit operands are latched on a
// start request, then one bit pair plus the registered carry passes through
// a single shared full adder per clock, LSB first. After WIDTH cycles the
// result, the final carry and the signed overflow are published together
// with a one-cycle done pulse.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   start    begin an operation (accepted in IDLE or DONE only)
//   sub      0 = a+b, 1 = a-b (sampled with start)
//   a, b     WIDTH-bit operands (sampled with start)
//   busy     high while bits are being processed
//   done     one-cycle pulse when result/cout/overflow update
//   result   sum or difference, held until the next completion
//   cout     final carry; for subtraction 1 means no borrow
//   overflow two's-complement overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------

// Single-bit full adder; the only arithmetic element of the engine.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] shreg;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;

   full_adder u_fa (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign busy     = (state == S_RUN);
   assign done     = (state == S_DONE);

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: state_nxt = start ? S_RUN : S_IDLE;
         S_RUN:          state_nxt = last_bit ? S_DONE : S_RUN;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op_a     <= '0;
         op_b     <= '0;
         shreg    <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1: invert B, seed the carry with 1.
                  op_a  <= a;
                  op_b  <= b ^ {WIDTH{sub}};
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               shreg <= {fa_sum, shreg[WIDTH-1:1]};
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  // On the MSB cycle the carry register holds the carry into
                  // the MSB, so overflow needs no extra capture stage.
                  result   <= {fa_sum, shreg[WIDTH-1:1]};
                  cout     <= fa_cout;
                  overflow <= carry ^ fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract engine built around a single `full_adder` instance, which it sequences one bit per clock. It latches two WIDTH-bit operands on a start pulse and feeds one bit pair plus the registered carry through the shared full adder each cycle. After WIDTH cycles it publishes the result, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic option in the datapath, for use wherever latency is cheaper than a ripple-carry array.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE or DONE.
- `sub`  in  1  operation select, sampled with `start`: 0 = a+b, 1 = a−b.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  high while bits are being processed (RUN state).
- `done`  out  1  one-cycle pulse when the outputs below are updated.
- `result`  out  WIDTH  sum or difference; holds its value until the next completion.
- `cout`  out  1  final carry. For subtraction, 1 means no borrow (a ≥ b unsigned).
- `overflow`  out  1  two's-complement overflow, computed as carry into MSB XOR carry out of MSB.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE or DONE with `start`=1:**
  - opA ← `a`.
  - opB ← `b` XOR {WIDTH{`sub`}}.
  - carry ← `sub`.
  - bit counter ← 0.
  - next state RUN.
- **IDLE without `start`:** stay in IDLE.
- **DONE without `start`:** go to IDLE.
- **RUN, each cycle:**
  - `full_adder` inputs: a=opA[0], b=opB[0], cin=carry.
  - Sum bit shifts into the MSB of the internal shift register (shift right), so after WIDTH shifts bit 0 lands in position 0.
  - carry ← adder cout.
  - opA and opB shift right by 1.
  - Counter increments.
  - On the bit with counter = WIDTH−1, the incoming carry (carry into the MSB) is also captured for the overflow calculation.
- **RUN, last bit (counter = WIDTH−1):**
  - `result` ← completed shift-register value, including that final sum bit.
  - `cout` ← adder cout.
  - `overflow` ← captured MSB carry-in XOR adder cout.
  - next state DONE.
- **Start handling:** `start` during RUN is ignored; the operands are not re-latched.
- **Operand stability:** `a`, `b` and `sub` are don't-care outside the start-sampling cycle.
- **Carry wrap:** the carry out of the MSB is not fed back into anything; it appears only on `cout`.
- **Sole datapath:** exactly one `full_adder` instance does all arithmetic. No `+` or `-` operator is used on operand data; counter arithmetic is exempt.

## Timing
- **Reset values:** `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0. All internal registers are cleared and the state is IDLE.
- **Reset mid-operation:** aborts immediately and clears the outputs. The first `start` after `rst` deasserts is accepted normally.
- **Latency:**
  - `start` is sampled at edge E0.
  - `busy`=1 from E0 through edge E0+WIDTH.
  - `result`, `cout` and `overflow` update at edge E0+WIDTH.
  - `done`=1 for exactly the cycle between edges E0+WIDTH and E0+WIDTH+1.
  - Total latency is WIDTH cycles.
- **Back-to-back operations:** `start` held or re-asserted during the DONE cycle is accepted. The next operation then completes WIDTH cycles later, giving a throughput of one operation per WIDTH+1 cycles.
- **Output hold:** `done` and `busy` are never high together. `result`, `cout` and `overflow` stay stable from one done pulse until the next, including through a following RUN.

## Test plan
All scenarios use WIDTH=8.
- **Basic add with latency check:** `a`=0x0F, `b`=0x01, `sub`=0, start at E0 -> `result`=0x10, `cout`=0, `overflow`=0. `done` is high only in the cycle after E0+8, and `busy` is high for 8 cycles.
- **Carry and overflow on add:** 0x7F+0x01 -> `result`=0x80, `cout`=0, `overflow`=1. Then 0xFF+0x01 -> `result`=0x00, `cout`=1, `overflow`=0.
- **Subtraction:** 0x05−0x07 -> `result`=0xFE, `cout`=0 (borrow), `overflow`=0. Then 0x80−0x01 -> `result`=0x7F, `cout`=1, `overflow`=1.
- **Start during RUN ignored:** pulse `start` with `a`=0x11, `b`=0x22 three cycles after launching 0x0F+0x01 -> outputs remain 0x10 / 0 / 0 with a single `done` pulse; no second operation is started.
- **Back-to-back start:** assert `start` with 0x03+0x04 during the DONE cycle of the previous operation -> `result`=0x07 exactly 8 cycles later; the state never visits IDLE between the two operations.
- **Reset mid-run:** assert `rst` asynchronously 4 cycles into an operation -> all outputs are 0 immediately and no `done` pulse occurs. A fresh 0x01+0x01 afterwards gives `result`=0x02 with normal latency.
